// File: rtl/md5_msg_feeder.sv
// rtl/md5_msg_feeder.sv - MD5 message padder and block emitter (optional MD5_FEED_PREPADDED_EN)
module md5_msg_feeder #(
    parameter int DATA_WIDTH   = 32,
    parameter int ROUND_CYCLES = 64,
    parameter int IDLE_GAP     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  MsgVld,
    output logic                  MsgRdy,
    input  logic [DATA_WIDTH-1:0] MsgData,
    input  logic                  MsgLast,
    input  logic [2:0]            MsgBytes,
`ifdef MD5_FEED_PREPADDED_EN
    input  logic                  PrePadded,
`endif
    output logic                  DataVld,
    output logic [DATA_WIDTH-1:0] DataIn,
    output logic                  Busy,
    output logic                  MsgDone
);

    typedef enum logic [1:0] {S_FILL, S_PAD, S_EMIT, S_GAP} state_t;

    // Last counter value of a block window, measured from its first DataVld cycle.
    localparam logic [7:0] GAP_LAST = 8'(ROUND_CYCLES + IDLE_GAP - 1);
    localparam logic [DATA_WIDTH-1:0] MARK_WORD = 32'h8000_0000;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] buf_q [16];
    logic [DATA_WIDTH-1:0] buf_d [16];
    logic [3:0]            widx_q, widx_d;
    logic [63:0]           len_q, len_d;
    logic [7:0]            cnt_q, cnt_d;
    logic                  last_q, last_d;       // block being built/emitted ends the message
    logic                  lenblk_q, lenblk_d;   // a length-only block follows this one
    logic                  lenonly_q, lenonly_d; // current emission is the synthesized length-only block
    logic                  mark_q, mark_d;       // 0x80 marker still owed to the next free word
    logic                  ovf_q, ovf_d;         // marker landed in word 14/15, no room for the length
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  pp_q, pp_d;           // current message is pre-padded
    logic                  pp_now;
    logic                  xfer;
    logic [2:0]            nbytes;
    logic [DATA_WIDTH-1:0] last_word;

    function automatic logic [31:0] byte_swap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    assign MsgRdy  = (state_q == S_FILL) & ~rst;
    assign xfer    = MsgVld & MsgRdy;
    assign DataVld = (state_q == S_EMIT);
    assign Busy    = busy_q;
    assign MsgDone = done_q;

`ifdef MD5_FEED_PREPADDED_EN
    assign pp_now = busy_q ? pp_q : PrePadded;
`else
    assign pp_now = 1'b0;
`endif

    // Effective byte count and final-word image with the 0x80 marker appended after the valid bytes.
    always_comb begin
        nbytes = (!MsgLast || MsgBytes > 3'd4) ? 3'd4 : MsgBytes;
        case (nbytes)
            3'd0:    last_word = MARK_WORD;
            3'd1:    last_word = {MsgData[31:24], 8'h80, 16'h0000};
            3'd2:    last_word = {MsgData[31:16], 8'h80, 8'h00};
            3'd3:    last_word = {MsgData[31:8], 8'h80};
            default: last_word = MsgData;
        endcase
    end

    // Emission mux: buffered block, or the all-zero-plus-length block computed on the fly.
    always_comb begin
        DataIn = '0;
        if (state_q == S_EMIT) begin
            if (!lenonly_q)
                DataIn = buf_q[widx_q];
            else if (widx_q == 4'd14)
                DataIn = byte_swap(len_q[31:0]);
            else if (widx_q == 4'd15)
                DataIn = byte_swap(len_q[63:32]);
        end
    end

    // Next-state logic: fill, pad, emit and round-cadence gap.
    always_comb begin
        state_d   = state_q;
        buf_d     = buf_q;
        widx_d    = widx_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        lenblk_d  = lenblk_q;
        lenonly_d = lenonly_q;
        mark_d    = mark_q;
        ovf_d     = ovf_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        pp_d      = pp_q;
        case (state_q)
            S_FILL: begin
                if (xfer) begin
                    busy_d = 1'b1;
                    pp_d   = pp_now;
                    len_d  = len_q + {58'd0, nbytes, 3'd0};
                    widx_d = widx_q + 4'd1;
                    if (pp_now) begin
                        buf_d[widx_q] = MsgData;
                        if (widx_q == 4'd15) begin
                            state_d = S_EMIT;
                            cnt_d   = '0;
                            last_d  = MsgLast;
                        end else if (MsgLast) begin
                            state_d = S_PAD;
                        end
                    end else if (!MsgLast) begin
                        buf_d[widx_q] = MsgData;
                        if (widx_q == 4'd15) begin
                            state_d = S_EMIT;
                            cnt_d   = '0;
                        end
                    end else begin
                        buf_d[widx_q] = last_word;
                        if (widx_q == 4'd15) begin
                            // Block is full: the marker (if not yet placed) and length go in later blocks.
                            state_d  = S_EMIT;
                            cnt_d    = '0;
                            last_d   = 1'b0;
                            mark_d   = (nbytes == 3'd4);
                            lenblk_d = (nbytes != 3'd4);
                        end else begin
                            state_d = S_PAD;
                            mark_d  = (nbytes == 3'd4);
                            ovf_d   = (widx_q == 4'd14) || (widx_q == 4'd13 && nbytes == 3'd4);
                        end
                    end
                end
            end
            S_PAD: begin
                if (pp_q || ovf_q || (widx_q < 4'd14 && !mark_q))
                    buf_d[widx_q] = '0;
                else if (mark_q)
                    buf_d[widx_q] = MARK_WORD;
                else if (widx_q == 4'd14)
                    buf_d[widx_q] = byte_swap(len_q[31:0]);
                else
                    buf_d[widx_q] = byte_swap(len_q[63:32]);
                if (mark_q && !pp_q)
                    buf_d[widx_q] = MARK_WORD;
                mark_d = 1'b0;
                widx_d = widx_q + 4'd1;
                if (widx_q == 4'd15) begin
                    state_d  = S_EMIT;
                    cnt_d    = '0;
                    last_d   = pp_q | ~ovf_q;
                    lenblk_d = ~pp_q & ovf_q;
                    ovf_d    = 1'b0;
                end
            end
            S_EMIT: begin
                widx_d = widx_q + 4'd1;
                cnt_d  = cnt_q + 8'd1;
                if (widx_q == 4'd15)
                    state_d = S_GAP;
            end
            default: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == GAP_LAST) begin
                    if (lenblk_q) begin
                        state_d   = S_EMIT;
                        cnt_d     = '0;
                        lenonly_d = 1'b1;
                        lenblk_d  = 1'b0;
                        last_d    = 1'b1;
                    end else if (last_q) begin
                        state_d   = S_FILL;
                        done_d    = 1'b1;
                        busy_d    = 1'b0;
                        len_d     = '0;
                        last_d    = 1'b0;
                        lenonly_d = 1'b0;
                        pp_d      = 1'b0;
                    end else if (mark_q) begin
                        state_d = S_PAD;
                    end else begin
                        state_d = S_FILL;
                    end
                end
            end
        endcase
    end

    // Control registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FILL;
            widx_q    <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            last_q    <= 1'b0;
            lenblk_q  <= 1'b0;
            lenonly_q <= 1'b0;
            mark_q    <= 1'b0;
            ovf_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pp_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            widx_q    <= widx_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            lenblk_q  <= lenblk_d;
            lenonly_q <= lenonly_d;
            mark_q    <= mark_d;
            ovf_q     <= ovf_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pp_q      <= pp_d;
        end
    end

    // Block buffer; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 16; i++)
            buf_q[i] <= buf_d[i];
    end

endmodule

// File: tb/tb_md5_msg_feeder.sv
// tb/tb_md5_msg_feeder.sv - directed self-checking bench for md5_msg_feeder
module tb_md5_msg_feeder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        MsgVld = 1'b0;
    logic        MsgRdy;
    logic [31:0] MsgData = '0;
    logic        MsgLast = 1'b0;
    logic [2:0]  MsgBytes = '0;
    logic        DataVld;
    logic [31:0] DataIn;
    logic        Busy;
    logic        MsgDone;
`ifdef MD5_FEED_PREPADDED_EN
    logic        PrePadded = 1'b0;
`endif

    md5_msg_feeder dut (
        .clk      (clk),
        .rst      (rst),
        .MsgVld   (MsgVld),
        .MsgRdy   (MsgRdy),
        .MsgData  (MsgData),
        .MsgLast  (MsgLast),
        .MsgBytes (MsgBytes),
`ifdef MD5_FEED_PREPADDED_EN
        .PrePadded(PrePadded),
`endif
        .DataVld  (DataVld),
        .DataIn   (DataIn),
        .Busy     (Busy),
        .MsgDone  (MsgDone)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          passed = 0;
    int          cyc = 0;
    logic [31:0] words[$];
    int          rises[$];
    logic        prev_vld = 1'b0;
    int          win = 0;
    int          viol = 0;
    bit          done_seen = 1'b0;
    int          done_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Passive monitor: collects emitted words, block start cycles, done pulses, ready leaks.
    always @(negedge clk) begin
        if (DataVld) words.push_back(DataIn);
        if (DataVld && !prev_vld) begin
            rises.push_back(cyc);
            win = 65;
        end
        if (win > 0) begin
            if (MsgRdy) viol++;
            win--;
        end
        prev_vld = DataVld;
        if (MsgDone) begin
            done_seen = 1'b1;
            done_cyc  = cyc;
        end
    end

    function automatic logic [31:0] pat(input int i);
        return {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
    endfunction

    task automatic clear_mon();
        words.delete();
        rises.delete();
        done_seen = 1'b0;
    endtask

    // Called at a negedge; returns at a negedge after the word transferred.
    task automatic send_word(input logic [31:0] d, input logic [2:0] b, input logic l, output int acc);
        logic r;
        int   n = 0;
        MsgVld = 1'b1; MsgData = d; MsgBytes = b; MsgLast = l;
        acc = -1;
        while (n < 3000) begin
            r = MsgRdy;
            if (r) acc = cyc;
            @(posedge clk);
            @(negedge clk);
            if (r) break;
            n++;
        end
        MsgVld = 1'b0; MsgLast = 1'b0;
        if (acc < 0) begin
            checks++;
            $display("FAIL send_word timeout data=%h", d);
        end
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!done_seen && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!done_seen) $display("FAIL wait_done got no MsgDone want pulse within %0d cycles", budget);
        else passed++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (MsgRdy !== 1'b0) $display("FAIL rst_rdy got %b want 0", MsgRdy); else passed++;
        rst = 1'b0;
        #1;
        checks++;
        if (MsgRdy !== 1'b1) $display("FAIL reset_rdy got %b want 1", MsgRdy); else passed++;
        checks++;
        if ({DataVld, Busy, MsgDone} !== 3'b000) $display("FAIL reset_outs got %b want 000", {DataVld, Busy, MsgDone}); else passed++;
        checks++;
        if (DataIn !== 32'h0) $display("FAIL reset_datain got %h want 00000000", DataIn); else passed++;
        @(negedge clk);
    endtask

    task automatic test_abc();
        int acc;
        int nz = 0;
        clear_mon();
        send_word(32'h6162_6300, 3'd3, 1'b1, acc);
        checks++;
        if (Busy !== 1'b1) $display("FAIL abc_busy got %b want 1", Busy); else passed++;
        wait_done(500);
        checks++;
        if (words.size() != 16) $display("FAIL abc_count got %0d want 16", words.size()); else passed++;
        if (words.size() == 16) begin
            checks++;
            if (words[0] !== 32'h6162_6380) $display("FAIL abc_w0 got %h want 61626380", words[0]); else passed++;
            checks++;
            if (words[14] !== 32'h1800_0000) $display("FAIL abc_w14 got %h want 18000000", words[14]); else passed++;
            for (int i = 1; i < 16; i++) if (i != 14 && words[i] != 0) nz++;
            checks++;
            if (nz != 0) $display("FAIL abc_zero got %0d nonzero words want 0", nz); else passed++;
        end
        checks++;
        if (rises.size() < 1 || done_cyc - rises[0] != 65)
            $display("FAIL abc_done_lat got %0d want 65", rises.size() < 1 ? -1 : done_cyc - rises[0]);
        else passed++;
        checks++;
        if (Busy !== 1'b0) $display("FAIL abc_busy_end got %b want 0", Busy); else passed++;
    endtask

    task automatic test_empty();
        int acc;
        int nz = 0;
        clear_mon();
        send_word(32'hDEAD_BEEF, 3'd0, 1'b1, acc);
        wait_done(500);
        checks++;
        if (words.size() != 16) $display("FAIL empty_count got %0d want 16", words.size()); else passed++;
        if (words.size() == 16) begin
            checks++;
            if (words[0] !== 32'h8000_0000) $display("FAIL empty_w0 got %h want 80000000", words[0]); else passed++;
            for (int i = 1; i < 16; i++) if (words[i] != 0) nz++;
            checks++;
            if (nz != 0) $display("FAIL empty_zero got %0d nonzero want 0", nz); else passed++;
        end
    endtask

    task automatic test_55_bytes();
        int acc;
        clear_mon();
        for (int i = 0; i < 13; i++) send_word(pat(i), 3'd4, 1'b0, acc);
        send_word(32'h3435_3600, 3'd3, 1'b1, acc);
        wait_done(600);
        checks++;
        if (words.size() != 16) $display("FAIL b55_count got %0d want 16", words.size()); else passed++;
        if (words.size() == 16) begin
            checks++;
            if (words[5] !== pat(5)) $display("FAIL b55_w5 got %h want %h", words[5], pat(5)); else passed++;
            checks++;
            if (words[13] !== 32'h3435_3680) $display("FAIL b55_w13 got %h want 34353680", words[13]); else passed++;
            checks++;
            if (words[14] !== 32'hB801_0000) $display("FAIL b55_w14 got %h want b8010000", words[14]); else passed++;
            checks++;
            if (words[15] !== 32'h0) $display("FAIL b55_w15 got %h want 00000000", words[15]); else passed++;
        end
    endtask

    task automatic test_56_bytes();
        int acc;
        int nz = 0;
        clear_mon();
        for (int i = 0; i < 14; i++) send_word(pat(i), 3'd4, i == 13, acc);
        wait_done(800);
        checks++;
        if (words.size() != 32) $display("FAIL b56_count got %0d want 32", words.size()); else passed++;
        if (words.size() == 32) begin
            checks++;
            if (words[13] !== pat(13)) $display("FAIL b56_w13 got %h want %h", words[13], pat(13)); else passed++;
            checks++;
            if (words[14] !== 32'h8000_0000) $display("FAIL b56_w14 got %h want 80000000", words[14]); else passed++;
            checks++;
            if (words[15] !== 32'h0) $display("FAIL b56_w15 got %h want 00000000", words[15]); else passed++;
            for (int i = 16; i < 30; i++) if (words[i] != 0) nz++;
            checks++;
            if (nz != 0) $display("FAIL b56_blk2_zero got %0d nonzero want 0", nz); else passed++;
            checks++;
            if (words[30] !== 32'hC001_0000) $display("FAIL b56_blk2_w14 got %h want c0010000", words[30]); else passed++;
            checks++;
            if (words[31] !== 32'h0) $display("FAIL b56_blk2_w15 got %h want 00000000", words[31]); else passed++;
        end
        checks++;
        if (rises.size() != 2 || rises[1] - rises[0] != 65)
            $display("FAIL b56_spacing got %0d want 65", rises.size() != 2 ? -1 : rises[1] - rises[0]);
        else passed++;
    endtask

    task automatic test_back_to_back();
        int acc;
        int acc15 = 0;
        int bad = 0;
        clear_mon();
        viol = 0;
        for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send_word(pat(i), 3'd4, i == 19, acc);
            if (i == 15) acc15 = acc;
        end
        wait_done(800);
        checks++;
        if (rises.size() < 1 || rises[0] <= acc15)
            $display("FAIL rnd_first_emit got %0d want after %0d", rises.size() < 1 ? -1 : rises[0], acc15);
        else passed++;
        checks++;
        if (viol != 0) $display("FAIL rnd_rdy_leak got %0d want 0", viol); else passed++;
        checks++;
        if (words.size() != 32) $display("FAIL rnd_count got %0d want 32", words.size()); else passed++;
        if (words.size() == 32) begin
            for (int i = 0; i < 20; i++) if (words[i] !== pat(i)) bad++;
            checks++;
            if (bad != 0) $display("FAIL rnd_data got %0d bad words want 0", bad); else passed++;
            checks++;
            if (words[20] !== 32'h8000_0000) $display("FAIL rnd_mark got %h want 80000000", words[20]); else passed++;
            checks++;
            if (words[30] !== 32'h8002_0000) $display("FAIL rnd_len got %h want 80020000", words[30]); else passed++;
        end
    endtask

    task automatic test_reset_mid_emit();
        int acc;
        int n = 0;
        clear_mon();
        send_word(32'h6162_6300, 3'd3, 1'b1, acc);
        while (!DataVld && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!DataVld) $display("FAIL rme_start got no DataVld want emission within 100 cycles"); else passed++;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({DataVld, Busy} !== 2'b00) $display("FAIL rme_drop got %b want 00", {DataVld, Busy}); else passed++;
        rst = 1'b0;
        @(negedge clk);
        clear_mon();
        send_word(32'h6162_6300, 3'd3, 1'b1, acc);
        wait_done(500);
        checks++;
        if (words.size() != 16 || words[0] !== 32'h6162_6380 || words[14] !== 32'h1800_0000)
            $display("FAIL rme_abc got n=%0d w0=%h w14=%h want 16 61626380 18000000",
                     words.size(), words.size() > 0 ? words[0] : 32'h0, words.size() > 14 ? words[14] : 32'h0);
        else passed++;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_abc();
        @(negedge clk);
        test_empty();
        @(negedge clk);
        test_55_bytes();
        @(negedge clk);
        test_56_bytes();
        @(negedge clk);
        test_back_to_back();
        @(negedge clk);
        test_reset_mid_emit();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/md5_msg_feeder.md
Name: md5_msg_feeder

Overview:
- Transmit side of the MD5 core data interface; the source for the core's DataVld/DataIn word stream.
- Accepts a raw message as a handshaked 32-bit word stream and applies MD5 padding (0x80, zero fill, 64-bit little-endian bit length).
- Buffers each 512-bit block, then emits it as 16 back-to-back words aligned to the core's 64-round cadence.
- The core samples words at fixed round slots and cannot be stalled, so each block is fully buffered before emission.

Parameters:
- DATA_WIDTH, 32, word width; fixed at 32 for MD5.
- ROUND_CYCLES, 64, core cycles per block, counted from the first DataVld cycle.
- IDLE_GAP, 1, minimum DataVld-low cycles after a block's last round before the next block starts.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- MsgVld  in  1  input word valid.
- MsgRdy  out  1  feeder can accept a word.
- MsgData  in  32  message bytes; the first byte in stream order is in [31:24].
- MsgLast  in  1  final word of the message.
- MsgBytes  in  3  valid bytes in this word, 1..4, left-justified; 0 is legal only with MsgLast (empty tail).
- DataVld  out  1  block word valid to the MD5 core.
- DataIn  out  32  block word to the MD5 core.
- Busy  out  1  high from the first accepted word until the last block's gap completes.
- MsgDone  out  1  one-cycle pulse when the final block's gap completes.

Behaviour:
- Reset (rst=1 at a clk edge): every output is 0, the FSM goes to FILL, and the word index, length counter and gap counter clear. Reset mid-emission drops DataVld on the next cycle. Buffer contents are don't-care.
- Transfer rule: a word transfers on a cycle with MsgVld & MsgRdy. MsgRdy = (state==FILL) & ~rst.
- Storage: 16x32 block buffer plus a 4-bit word index `widx`.
- Length counter: 64-bit bit count. Add MsgBytes*8 per transfer; wraps modulo 2^64.
- FILL state:
  - Each transfer writes the word to buf[widx] and increments widx.
  - Non-last word with MsgBytes!=4 is a protocol error. Treat it as 4 bytes.
  - If widx wraps 15->0 on a non-last word, go to EMIT.
  - On MsgLast, write the 0x80 byte into the byte lane immediately after the valid bytes, with zeros below it:
    - MsgBytes=4: 0x80000000 goes into the next word, which needs one extra slot.
    - MsgBytes=0: that word becomes 0x80000000.
  - Then go to PAD.
- PAD state: one buffer word per cycle.
  - Zero-fill up to word 13.
  - If the 0x80 marker (or its slot) landed in word 14 or 15: zero-fill to word 15, emit the block, and mark that a length-only block follows. That block is words 0..13 zero plus the length.
  - Otherwise write word14 = byte_swap(len[31:0]) and word15 = byte_swap(len[63:32]), then go to EMIT with the last flag set.
- EMIT state:
  - DataVld=1 for exactly 16 consecutive cycles, with DataIn=buf[0..15] in order.
  - DataIn=0 whenever DataVld=0.
- GAP state:
  - DataVld=0 until ROUND_CYCLES+IDLE_GAP cycles have elapsed since the first EMIT cycle.
  - Then go to FILL (more message), PAD (pending length-only block), or FILL with a MsgDone pulse (message complete).
- Busy drops in the same cycle MsgDone pulses.
- A new message may begin on the cycle after MsgDone. The length counter clears at MsgDone.
- Input during PAD, EMIT or GAP is held off by MsgRdy=0.

Optional Feature:
- Macro: MD5_FEED_PREPADDED_EN.
- When defined: adds input port PrePadded (1 bit), sampled with the first word of a message.
  - If high, no 0x80, zero fill or length words are generated.
  - The message must be a multiple of 16 full words. Every 16 words are emitted as a block.
  - MsgLast on word 15 ends the message. MsgLast elsewhere is a protocol error: the remainder is zero-filled, and MsgDone still pulses.
- When undefined: the port is absent and padding is always applied.

Test Plan:
- "abc": one word 0x61626300, MsgBytes=3, MsgLast -> one block: word0=0x61626380, words1..13=0, word14=0x18000000, word15=0. MsgDone pulses 65 cycles after the first DataVld.
- Empty message: MsgBytes=0, MsgLast -> word0=0x80000000, words1..15=0.
- 55 bytes (13 full words plus a 3-byte tail) -> single block: word13 = bytes52..54 followed by 0x80; word14=0xB8010000.
- 56 bytes (14 full words, last with MsgBytes=4) -> two blocks:
  - Block 1: word14=0x80000000, word15=0.
  - Block 2: words0..13=0, word14=0xC0010000, word15=0.
  - Block 2's DataVld rises exactly 65 cycles after block 1's.
- 20-word message with MsgVld toggled randomly -> first block emits only after word 15 is accepted, and MsgRdy=0 throughout EMIT and GAP. Block 2 carries words 16..19, then 0x80000000, then len word14=0x80020000.
- Assert rst during the 8th EMIT cycle -> DataVld=0, Busy=0 next cycle. A fresh "abc" then produces the correct block.
